// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer, registered in_ready and
// branch resolution. Define EX_MEM_STATS_EN to add stall/retire counters.
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  zero_flag,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_W-1:0]     store_data,
    input  logic                  is_branch,
    input  logic                  br_on_zero,
    input  logic [DATA_W-1:0]     branch_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [DATA_W-1:0]     out_store_data,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     branch_pc
`ifdef EX_MEM_STATS_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           retire_cnt
`endif
);

    localparam int ENTRY_W = 2 * DATA_W + REG_ADDR_W + 3;

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] main_q, main_d, skid_q, skid_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               branch_taken_q, branch_taken_d;
    logic [DATA_W-1:0]  branch_pc_q, branch_pc_d;
    logic               accept, xfer, br_hit;

    assign in_entry = {alu_result, rd_addr, reg_write, mem_read, mem_write, store_data};
    assign accept   = in_valid & in_ready_q;
    assign xfer     = main_valid_q & out_ready;
    assign br_hit   = accept & is_branch & (zero_flag == br_on_zero);

    always_comb begin
        main_d         = main_q;
        skid_d         = skid_q;
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        branch_taken_d = 1'b0;
        branch_pc_d    = branch_pc_q;
        in_ready_d     = in_ready_q;
        if (flush) begin
            // Output fields read as zero while empty after a flush.
            main_d       = '0;
            skid_d       = '0;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            in_ready_d   = 1'b1;
        end else begin
            if (xfer) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = 1'b0;
                end
            end
            if (accept) begin
                if (!main_valid_q || (xfer && !skid_valid_q)) begin
                    main_d       = in_entry;
                    main_valid_d = 1'b1;
                end else begin
                    skid_d       = in_entry;
                    skid_valid_d = 1'b1;
                end
            end
            // Registered ready: only looks at next-cycle skid occupancy.
            in_ready_d     = !skid_valid_d;
            branch_taken_d = br_hit;
            if (br_hit) begin
                branch_pc_d = branch_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q         <= '0;
            skid_q         <= '0;
            main_valid_q   <= 1'b0;
            skid_valid_q   <= 1'b0;
            in_ready_q     <= 1'b1;
            branch_taken_q <= 1'b0;
            branch_pc_q    <= '0;
        end else begin
            main_q         <= main_d;
            skid_q         <= skid_d;
            main_valid_q   <= main_valid_d;
            skid_valid_q   <= skid_valid_d;
            in_ready_q     <= in_ready_d;
            branch_taken_q <= branch_taken_d;
            branch_pc_q    <= branch_pc_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid_q;
    assign branch_taken = branch_taken_q;
    assign branch_pc    = branch_pc_q;
    assign {out_result, out_rd_addr, out_reg_write, out_mem_read, out_mem_write,
            out_store_data} = main_q;

`ifdef EX_MEM_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Counters reflect the handshake seen on the ports, flush or not.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (main_valid_q && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (xfer) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus queues expected entries, a
// negedge monitor pops and compares them on every output transfer.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] store;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] alu_result, store_data, branch_target, out_result, out_store_data, branch_pc;
    logic        zero_flag, reg_write, mem_read, mem_write, is_branch, br_on_zero;
    logic [4:0]  rd_addr, out_rd_addr;
    logic        out_valid, out_ready, out_reg_write, out_mem_read, out_mem_write, branch_taken;
`ifdef EX_MEM_STATS_EN
    logic [31:0] stall_cnt, retire_cnt;
`endif

    entry_t sb[$];
    int     n_vec = 0;
    int     n_err = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .zero_flag(zero_flag), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .store_data(store_data), .is_branch(is_branch), .br_on_zero(br_on_zero),
        .branch_target(branch_target), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data), .branch_taken(branch_taken), .branch_pc(branch_pc)
`ifdef EX_MEM_STATS_EN
        , .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
`endif
    );

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of input; queue the expected entry if it will be accepted.
    task automatic drive(input logic v, input logic [31:0] res, input logic br,
                         input logic zf, input logic fl, output logic acc);
        entry_t e;
        in_valid      = v;
        alu_result    = res;
        rd_addr       = res[4:0];
        reg_write     = 1'b1;
        mem_read      = res[0];
        mem_write     = res[1];
        store_data    = ~res;
        is_branch     = br;
        br_on_zero    = 1'b1;
        zero_flag     = zf;
        branch_target = 32'h0000_0040;
        flush         = fl;
        acc           = v && in_ready && !fl && !reset;
        if (fl) sb.delete();
        if (acc) begin
            e = '{result: res, rd: res[4:0], rw: 1'b1, mr: res[0], mw: res[1], store: ~res};
            sb.push_back(e);
        end
    endtask

    initial begin : monitor
        entry_t exp_e, got_e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                got_e = '{result: out_result, rd: out_rd_addr, rw: out_reg_write,
                          mr: out_mem_read, mw: out_mem_write, store: out_store_data};
                if (sb.size() == 0) begin
                    chk("unexpected_output", {24'h0, got_e}, 96'h0);
                end else begin
                    exp_e = sb.pop_front();
                    chk("sb_entry", {24'h0, got_e}, {24'h0, exp_e});
                end
            end
        end
    end

    initial begin : stim
        logic acc;
        logic done;
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        tick; tick;
        reset = 1'b0;
        chk("rst_out_valid", {95'h0, out_valid}, 96'h0);
        chk("rst_in_ready", {95'h0, in_ready}, 96'h1);
        chk("rst_out_result", {64'h0, out_result}, 96'h0);
        chk("rst_branch_taken", {95'h0, branch_taken}, 96'h0);
        chk("rst_branch_pc", {64'h0, branch_pc}, 96'h0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, 1'b0, 1'b0, 1'b0, acc);
            tick;
            chk("stream_in_ready", {95'h0, in_ready}, 96'h1);
            chk("stream_latency", {63'h0, out_valid, out_result}, {63'h0, 1'b1, 32'(i)});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        tick;
        chk("drain_retains", {63'h0, out_valid, out_result}, {63'h0, 1'b0, 32'h8});

        // Backpressure: A held, B into skid, C refused until space frees
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, acc);
        tick;
        chk("bp_a_ready", {95'h0, in_ready}, 96'h1);
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, acc);
        tick;
        chk("bp_skid_ready", {95'h0, in_ready}, 96'h0);
        chk("bp_a_held", {64'h0, out_result}, 96'hA);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, acc);
        chk("bp_c_refused", {95'h0, acc}, 96'h0);
        tick;
        chk("bp_a_still_held", {64'h0, out_result}, 96'hA);
        out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 6 && !done; k++) begin
            drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, acc);
            tick;
            done = acc;
        end
        chk("bp_c_accepted", {95'h0, done}, 96'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        tick; tick; tick;
        chk("bp_sb_empty", 96'(sb.size()), 96'h0);

        // Branch resolution under downstream stall
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, acc);
        tick;
        chk("br_taken", {63'h0, branch_taken, branch_pc}, {63'h0, 1'b1, 32'h40});
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        tick;
        chk("br_one_cycle", {95'h0, branch_taken}, 96'h0);
        drive(1'b1, 32'h101, 1'b1, 1'b0, 1'b0, acc);
        tick;
        chk("br_not_taken", {95'h0, branch_taken}, 96'h0);
        chk("br_both_full", {95'h0, in_ready}, 96'h0);

        // Flush with both entries full, input carrying a taken branch
        drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, acc);
        tick;
        chk("fl_state", {93'h0, out_valid, in_ready, branch_taken}, {93'h0, 3'b010});
        chk("fl_zero_data", {64'h0, out_result}, 96'h0);
        drive(1'b1, 32'h201, 1'b1, 1'b1, 1'b1, acc);
        tick;
        chk("fl_no_pulse", {94'h0, out_valid, branch_taken}, 96'h0);
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, acc);
        tick;
        chk("fl_then_55", {63'h0, out_valid, out_result}, {63'h0, 1'b1, 32'h55});
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        tick;

        // Fresh reset, stall counting, then reset mid-stream with entries held
        reset = 1'b1;
        sb.delete();
        tick;
        reset = 1'b0;
`ifdef EX_MEM_STATS_EN
        chk("stats_clear", {32'h0, stall_cnt, retire_cnt}, 96'h0);
`endif
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, acc);
        tick;
        drive(1'b1, 32'h78, 1'b0, 1'b0, 1'b0, acc);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        tick;
        tick;
`ifdef EX_MEM_STATS_EN
        chk("stall_cnt_3", {64'h0, stall_cnt}, 96'h3);
`endif
        chk("mid_full", {94'h0, out_valid, in_ready}, {94'h0, 2'b10});
        reset = 1'b1;
        sb.delete();
        tick;
        reset = 1'b0;
        chk("mid_rst_ctrl", {93'h0, out_valid, in_ready, branch_taken}, {93'h0, 3'b010});
        chk("mid_rst_data", {out_result, out_store_data, 27'h0, out_rd_addr},
            96'h0);
        chk("mid_rst_flags", {93'h0, out_reg_write, out_mem_read, out_mem_write}, 96'h0);
`ifdef EX_MEM_STATS_EN
        chk("stall_cnt_rst", {64'h0, stall_cnt}, 96'h0);
`endif
        tick;
        chk("final_sb_empty", 96'(sb.size()), 96'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
